relu_stream: RTL and testbench

//  AXI-Stream ReLU stage directly upstream of the pool block; feeds its S_AXIS port.

---
 rtl/relu_stream.sv | 120 ++++++++++++
 tb/tb_relu_stream.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/relu_stream.sv
// AXI-Stream ReLU stage: zeroes negative int8 lanes, registers the word and
// regenerates TLAST from the latched frame size, with a start/done handshake.
module relu_stream #(
  parameter int C_S00_AXIS_TDATA_WIDTH = 32,
  parameter int LANE_W                 = 8
) (
  input  logic                                  clk,
  input  logic                                  rstn,
  output logic                                  S_AXIS_TREADY,
  input  logic [C_S00_AXIS_TDATA_WIDTH-1:0]     S_AXIS_TDATA,
  input  logic [C_S00_AXIS_TDATA_WIDTH/8-1:0]   S_AXIS_TKEEP,
  input  logic                                  S_AXIS_TUSER,
  input  logic                                  S_AXIS_TLAST,
  input  logic                                  S_AXIS_TVALID,
  input  logic                                  M_AXIS_TREADY,
  output logic                                  M_AXIS_TUSER,
  output logic [C_S00_AXIS_TDATA_WIDTH-1:0]     M_AXIS_TDATA,
  output logic [C_S00_AXIS_TDATA_WIDTH/8-1:0]   M_AXIS_TKEEP,
  output logic                                  M_AXIS_TLAST,
  output logic                                  M_AXIS_TVALID,
  input  logic                                  relu_start,
  output logic                                  relu_done,
  input  logic [5:0]                            flen,
  input  logic [8:0]                            in_channel,
  output logic                                  tlast_err
);

  localparam int LANES = C_S00_AXIS_TDATA_WIDTH / LANE_W;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                            state_reg;
  logic [16:0]                       total_reg;
  logic [16:0]                       in_cnt_reg;
  logic [16:0]                       out_cnt_reg;
  logic [19:0]                       prod;
  logic [16:0]                       total_calc;
  logic [C_S00_AXIS_TDATA_WIDTH-1:0] relu_word;
  logic                              in_hs;
  logic                              out_hs;
  logic                              last_in;
  logic                              unused_bits;

  // 32*32*256 = 2^18 fits in 20 bits; dividing by 4 leaves a 17-bit word count.
  assign prod       = 20'(flen) * 20'(flen) * 20'(in_channel);
  assign total_calc = prod[18:2];
  assign unused_bits = ^{S_AXIS_TKEEP, prod[19], prod[1:0]};

  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      assign relu_word[gi*LANE_W +: LANE_W] =
        S_AXIS_TDATA[gi*LANE_W + LANE_W - 1] ? '0 : S_AXIS_TDATA[gi*LANE_W +: LANE_W];
    end
  endgenerate

  assign M_AXIS_TKEEP  = '1;
  assign S_AXIS_TREADY = (state_reg == RUN) && (in_cnt_reg < total_reg) &&
                         (!M_AXIS_TVALID || M_AXIS_TREADY);
  assign in_hs   = S_AXIS_TVALID && S_AXIS_TREADY;
  assign out_hs  = M_AXIS_TVALID && M_AXIS_TREADY;
  assign last_in = (in_cnt_reg == total_reg - 17'd1);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_reg     <= IDLE;
      total_reg     <= '0;
      in_cnt_reg    <= '0;
      out_cnt_reg   <= '0;
      M_AXIS_TVALID <= 1'b0;
      M_AXIS_TLAST  <= 1'b0;
      M_AXIS_TUSER  <= 1'b0;
      M_AXIS_TDATA  <= '0;
      relu_done     <= 1'b0;
      tlast_err     <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (relu_start) begin
            state_reg   <= RUN;
            total_reg   <= total_calc;
            in_cnt_reg  <= '0;
            out_cnt_reg <= '0;
            tlast_err   <= 1'b0;
          end
        end
        RUN: begin
          if (out_hs && (out_cnt_reg == total_reg - 17'd1)) begin
            state_reg <= DONE;
            relu_done <= 1'b1;
          end
        end
        DONE: begin
          if (!relu_start) begin
            state_reg <= IDLE;
            relu_done <= 1'b0;
          end
        end
        default: state_reg <= IDLE;
      endcase

      // A fresh input word always wins; otherwise a consumed word empties the stage.
      if (in_hs) begin
        M_AXIS_TDATA  <= relu_word;
        M_AXIS_TUSER  <= S_AXIS_TUSER;
        M_AXIS_TVALID <= 1'b1;
        M_AXIS_TLAST  <= last_in;
        in_cnt_reg    <= in_cnt_reg + 17'd1;
        if (S_AXIS_TLAST != last_in)
          tlast_err <= 1'b1;
      end else if (out_hs) begin
        M_AXIS_TVALID <= 1'b0;
      end

      if (out_hs)
        out_cnt_reg <= out_cnt_reg + 17'd1;
    end
  end

endmodule

// File: tb/tb_relu_stream.sv
// Randomized scoreboard bench for relu_stream: driver pushes expected beats,
// an independent monitor pops and compares every output handshake.
module tb_relu_stream;

  logic        clk = 1'b0;
  logic        rstn;
  logic        S_AXIS_TREADY;
  logic [31:0] S_AXIS_TDATA;
  logic [3:0]  S_AXIS_TKEEP;
  logic        S_AXIS_TUSER;
  logic        S_AXIS_TLAST;
  logic        S_AXIS_TVALID;
  logic        M_AXIS_TREADY;
  logic        M_AXIS_TUSER;
  logic [31:0] M_AXIS_TDATA;
  logic [3:0]  M_AXIS_TKEEP;
  logic        M_AXIS_TLAST;
  logic        M_AXIS_TVALID;
  logic        relu_start;
  logic        relu_done;
  logic [5:0]  flen;
  logic [8:0]  in_channel;
  logic        tlast_err;

  always #5 clk = ~clk;

  relu_stream dut (
    .clk(clk), .rstn(rstn),
    .S_AXIS_TREADY(S_AXIS_TREADY), .S_AXIS_TDATA(S_AXIS_TDATA), .S_AXIS_TKEEP(S_AXIS_TKEEP),
    .S_AXIS_TUSER(S_AXIS_TUSER), .S_AXIS_TLAST(S_AXIS_TLAST), .S_AXIS_TVALID(S_AXIS_TVALID),
    .M_AXIS_TREADY(M_AXIS_TREADY), .M_AXIS_TUSER(M_AXIS_TUSER), .M_AXIS_TDATA(M_AXIS_TDATA),
    .M_AXIS_TKEEP(M_AXIS_TKEEP), .M_AXIS_TLAST(M_AXIS_TLAST), .M_AXIS_TVALID(M_AXIS_TVALID),
    .relu_start(relu_start), .relu_done(relu_done), .flen(flen), .in_channel(in_channel),
    .tlast_err(tlast_err)
  );

  typedef struct {
    logic [31:0] data;
    logic        last;
    logic        user;
  } beat_t;

  beat_t       exp_q[$];
  int          total_chk = 0;
  int          bad_chk = 0;
  int          ready_mode = 1;
  int          pat_idx = 0;
  bit          in_reset = 1'b1;
  int          beats_seen = 0;
  bit          pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
  logic [31:0] fixed_words[4] = '{32'h807FFF01, 32'h01020304, 32'hFFFFFFFF, 32'h00000010};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_chk++;
    if (act !== exp) begin
      bad_chk++;
      $display("FAIL %s: got=%0h want=%0h", name, act, exp);
    end
  endtask

  // Reference: each signed byte below zero becomes zero.
  function automatic logic [31:0] relu_ref(input logic [31:0] w);
    logic [31:0] r;
    int v;
    r = '0;
    for (int l = 0; l < 4; l++) begin
      v = int'($signed(w[8*l +: 8]));
      if (v < 0) v = 0;
      r[8*l +: 8] = 8'(v);
    end
    return r;
  endfunction

  // Monitor: chooses TREADY each cycle, checks hold-while-stalled, scores beats.
  initial begin : monitor
    bit          prev_stall;
    logic [33:0] prev_word;
    beat_t       b;
    prev_stall = 1'b0;
    prev_word  = '0;
    M_AXIS_TREADY = 1'b1;
    forever begin
      @(negedge clk);
      case (ready_mode)
        0:       M_AXIS_TREADY = 1'($urandom_range(0, 1));
        2: begin M_AXIS_TREADY = pat[pat_idx % 4]; pat_idx++; end
        default: M_AXIS_TREADY = 1'b1;
      endcase
      if (in_reset) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          check("hold_valid", 64'(M_AXIS_TVALID), 64'd1);
          check("hold_word", 64'({M_AXIS_TLAST, M_AXIS_TUSER, M_AXIS_TDATA}), 64'(prev_word));
        end
        if (M_AXIS_TVALID && M_AXIS_TREADY) begin
          beats_seen++;
          if (exp_q.size() == 0) begin
            check("unexpected_beat", 64'(M_AXIS_TDATA), 64'hDEAD_0000_0000);
          end else begin
            b = exp_q.pop_front();
            $display("beat %0d: data=%08h last=%0b user=%0b exp=%08h/%0b/%0b", beats_seen,
                     M_AXIS_TDATA, M_AXIS_TLAST, M_AXIS_TUSER, b.data, b.last, b.user);
            check("beat_data", 64'(M_AXIS_TDATA), 64'(b.data));
            check("beat_last", 64'(M_AXIS_TLAST), 64'(b.last));
            check("beat_user", 64'(M_AXIS_TUSER), 64'(b.user));
          end
        end
        prev_stall = M_AXIS_TVALID && !M_AXIS_TREADY;
        prev_word  = {M_AXIS_TLAST, M_AXIS_TUSER, M_AXIS_TDATA};
      end
    end
  end

  // Driver: offers n words; pushes the expected output when the word is taken.
  task automatic drive(input int n, input int tot, input int err_idx, input bit gaps,
                       input bit fixed, output int stalls);
    int idx, waited;
    bit have;
    logic [31:0] w;
    logic u;
    stalls = 0; idx = 0; waited = 0; have = 1'b0; w = '0; u = 1'b0;
    while (idx < n) begin
      if (!have && gaps && $urandom_range(0, 3) == 0) begin
        S_AXIS_TVALID = 1'b0;
      end else begin
        if (!have) begin
          w = fixed ? fixed_words[idx % 4] : $urandom;
          u = 1'($urandom_range(0, 1));
          have = 1'b1;
        end
        S_AXIS_TVALID = 1'b1;
        S_AXIS_TDATA  = w;
        S_AXIS_TUSER  = u;
        S_AXIS_TLAST  = (err_idx >= 0) ? (idx == err_idx) : (idx == tot - 1);
        #2;
        if (S_AXIS_TREADY) begin
          exp_q.push_back(beat_t'{relu_ref(w), (idx == tot - 1), u});
          idx++;
          have = 1'b0;
        end else begin
          stalls++;
        end
      end
      @(negedge clk);
      waited++;
      if (waited > n * 8 + 200) begin
        check("drive_timeout", 64'(idx), 64'(n));
        break;
      end
    end
    S_AXIS_TVALID = 1'b0;
    S_AXIS_TLAST  = 1'b0;
  endtask

  task automatic wait_done(output int cycles);
    cycles = 0;
    while (!relu_done && cycles < 2000) begin
      @(negedge clk);
      cycles++;
    end
    if (!relu_done) check("done_timeout", 64'(relu_done), 64'd1);
  endtask

  task automatic run_frame(input int f, input int ch, input int err_idx, input bit gaps,
                           input bit fixed, input bit chk_lat, input bit perturb);
    int tot, stalls, cyc, beats0;
    bit exp_err;
    tot = f * f * ch / 4;
    exp_err = (err_idx >= 0) && (err_idx != tot - 1);
    flen = 6'(f);
    in_channel = 9'(ch);
    relu_start = 1'b1;
    @(negedge clk);
    check("start_err_clear", 64'(tlast_err), 64'd0);
    if (perturb) begin
      flen = 6'($urandom_range(1, 32));
      in_channel = 9'(4 * $urandom_range(1, 64));
    end
    relu_start = 1'($urandom_range(0, 1));
    beats0 = beats_seen;
    drive(tot, tot, err_idx, gaps, fixed, stalls);
    relu_start = 1'b1;
    wait_done(cyc);
    $display("frame flen=%0d ch=%0d words=%0d stalls=%0d done_after=%0d", f, ch, tot, stalls, cyc);
    if (chk_lat) begin
      check("done_latency", 64'(cyc), 64'd1);
      check("input_stalls", 64'(stalls), 64'd0);
    end
    check("beat_count", 64'(beats_seen - beats0), 64'(tot));
    check("queue_empty", 64'(exp_q.size()), 64'd0);
    check("valid_after_done", 64'(M_AXIS_TVALID), 64'd0);
    check("tlast_err", 64'(tlast_err), 64'(exp_err));
    S_AXIS_TVALID = 1'b1;
    S_AXIS_TDATA  = $urandom;
    #2;
    check("tready_after_end", 64'(S_AXIS_TREADY), 64'd0);
    @(negedge clk);
    S_AXIS_TVALID = 1'b0;
    check("done_held", 64'(relu_done), 64'd1);
    relu_start = 1'b0;
    @(negedge clk);
    check("done_drop", 64'(relu_done), 64'd0);
    check("tlast_err_sticky", 64'(tlast_err), 64'(exp_err));
  endtask

  initial begin : main
    int st;
    rstn = 1'b0;
    relu_start = 1'b0;
    flen = 6'd2;
    in_channel = 9'd4;
    S_AXIS_TDATA = 32'hA5A5A5A5;
    S_AXIS_TKEEP = 4'hF;
    S_AXIS_TUSER = 1'b1;
    S_AXIS_TLAST = 1'b1;
    S_AXIS_TVALID = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_outputs", 64'({M_AXIS_TVALID, M_AXIS_TLAST, M_AXIS_TUSER, relu_done, tlast_err, S_AXIS_TREADY}), 64'd0);
    check("rst_data", 64'(M_AXIS_TDATA), 64'd0);
    check("tkeep", 64'(M_AXIS_TKEEP), 64'hF);
    S_AXIS_TVALID = 1'b0;
    S_AXIS_TLAST = 1'b0;
    rstn = 1'b1;
    @(negedge clk);
    in_reset = 1'b0;

    ready_mode = 1;
    run_frame(2, 4, -1, 1'b0, 1'b1, 1'b1, 1'b0);
    ready_mode = 2; pat_idx = 0;
    run_frame(2, 4, -1, 1'b0, 1'b1, 1'b0, 1'b0);
    ready_mode = 1;
    run_frame(2, 4, 1, 1'b0, 1'b1, 1'b1, 1'b0);
    run_frame(1, 4, -1, 1'b0, 1'b0, 1'b1, 1'b0);

    // Reset in the middle of a frame.
    flen = 6'd2; in_channel = 9'd4; relu_start = 1'b1;
    @(negedge clk);
    relu_start = 1'b0;
    drive(2, 4, -1, 1'b0, 1'b1, st);
    in_reset = 1'b1;
    rstn = 1'b0;
    @(negedge clk);
    check("midrst_outputs", 64'({M_AXIS_TVALID, M_AXIS_TLAST, M_AXIS_TUSER, relu_done, tlast_err, S_AXIS_TREADY}), 64'd0);
    check("midrst_data", 64'(M_AXIS_TDATA), 64'd0);
    rstn = 1'b1;
    exp_q.delete();
    @(negedge clk);
    in_reset = 1'b0;
    check("postrst_quiet", 64'(M_AXIS_TVALID), 64'd0);
    run_frame(2, 4, -1, 1'b0, 1'b1, 1'b1, 1'b0);

    ready_mode = 0;
    for (int k = 0; k < 6; k++)
      run_frame($urandom_range(1, 4), 4 * $urandom_range(1, 4), -1, 1'b1, 1'b0, 1'b0, 1'b1);
    run_frame(3, 8, 5, 1'b1, 1'b0, 1'b0, 1'b1);

    ready_mode = 1;
    run_frame(32, 256, -1, 1'b0, 1'b0, 1'b1, 1'b0);

    $display("test done: total=%0d bad=%0d", total_chk, bad_chk);
    $finish;
  end

endmodule
